mat_mul_seq: RTL and testbench

//   Sequencer for the 8-bit unsigned MAC datapath: computes C = A x B for two N x N byte matrices.

---
 rtl/mat_mul_pkg.sv | 15 +
 rtl/mat_mul_idx_gen.sv | 54 +++++
 rtl/mat_mul_seq.sv | 139 +++++++++++++
 tb/tb_mat_mul_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_mul_pkg.sv
// Shared types and widths for the mat_mul_seq sequencer: FSM encoding and datapath widths.
package mat_mul_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 22;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mat_mul_idx_gen.sv
// Nested i/j/k index counters (k fastest) with wrap flags, advance enable and sync clear.
module mat_mul_idx_gen #(
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [LOG2N-1:0] i_o,
  output logic [LOG2N-1:0] j_o,
  output logic [LOG2N-1:0] k_o,
  output logic             i_last_o,
  output logic             j_last_o,
  output logic             k_last_o
);

  logic [LOG2N-1:0] i_q, i_d, j_q, j_d, k_q, k_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
      k_q <= k_d;
    end
  end

  // Counters wrap naturally at N-1 because N is a power of two.
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    k_d = k_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (adv_i) begin
      k_d = k_q + 1'b1;
      if (k_last_o) j_d = j_q + 1'b1;
      if (k_last_o && j_last_o) i_d = i_q + 1'b1;
    end
  end

  assign i_o      = i_q;
  assign j_o      = j_q;
  assign k_o      = k_q;
  assign i_last_o = &i_q;
  assign j_last_o = &j_q;
  assign k_last_o = &k_q;

endmodule

// File: rtl/mat_mul_seq.sv
// Sequencer for C = A x B over N x N byte matrices: read pipe, MAC feed, result capture.
// Optional output clamp to SAT_MAX enabled by defining MAT_MUL_SAT_EN.
module mat_mul_seq
  import mat_mul_pkg::*;
#(
  parameter int               LOG2N   = 3,
  parameter int               MAC_LAT = 1,
  parameter logic [ACC_W-1:0] SAT_MAX = 22'h00FFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [2*LOG2N-1:0]   a_addr,
  output logic [2*LOG2N-1:0]   b_addr,
  input  logic [DATA_W-1:0]    a_rdata,
  input  logic [DATA_W-1:0]    b_rdata,
  output logic [DATA_W-1:0]    mac_a,
  output logic [DATA_W-1:0]    mac_b,
  output logic [CNT_W-1:0]     mac_cnt,
  output logic                 mac_vld,
  input  logic [ACC_W-1:0]     mac_acc,
  output logic                 c_we,
  output logic [2*LOG2N-1:0]   c_addr,
  output logic [ACC_W-1:0]     c_wdata,
  output state_e               dbg_state
);

  localparam int AW = 2 * LOG2N;
`ifdef MAT_MUL_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic             idx_clr, last_rd;
  logic [LOG2N-1:0] i_idx, j_idx, k_idx;
  logic             i_last, j_last, k_last;

  logic             s2_vld_q, s2_klast_q, s2_last_q;
  logic [LOG2N-1:0] s2_k_q;
  logic [AW-1:0]    s2_ij_q;

  logic [MAC_LAT-1:0] cap_vld_q, cap_last_q;
  logic [AW-1:0]      cap_addr_q [MAC_LAT];

  mat_mul_idx_gen #(.LOG2N(LOG2N)) u_idx (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (idx_clr),
    .adv_i    (rd_en),
    .i_o      (i_idx),
    .j_o      (j_idx),
    .k_o      (k_idx),
    .i_last_o (i_last),
    .j_last_o (j_last),
    .k_last_o (k_last)
  );

  assign last_rd = i_last & j_last & k_last;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    done    = 1'b0;
    idx_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          idx_clr = 1'b1;
        end
      end
      ST_RUN: begin
        rd_en = 1'b1;
        if (last_rd) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (c_we && cap_last_q[MAC_LAT-1]) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage 2 mirrors the RAM read latency; the capture line then waits out the MAC latency
  // carrying the {i,j} of each finished dot product.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld_q   <= 1'b0;
      s2_klast_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_k_q     <= '0;
      s2_ij_q    <= '0;
      cap_vld_q  <= '0;
      cap_last_q <= '0;
      for (int n = 0; n < MAC_LAT; n++) cap_addr_q[n] <= '0;
    end else begin
      s2_vld_q      <= rd_en;
      s2_klast_q    <= rd_en & k_last;
      s2_last_q     <= rd_en & last_rd;
      s2_k_q        <= rd_en ? k_idx : '0;
      s2_ij_q       <= {i_idx, j_idx};
      cap_vld_q[0]  <= s2_klast_q;
      cap_last_q[0] <= s2_last_q;
      cap_addr_q[0] <= s2_ij_q;
      for (int n = 1; n < MAC_LAT; n++) begin
        cap_vld_q[n]  <= cap_vld_q[n-1];
        cap_last_q[n] <= cap_last_q[n-1];
        cap_addr_q[n] <= cap_addr_q[n-1];
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;
  assign a_addr    = {i_idx, k_idx};
  assign b_addr    = {k_idx, j_idx};
  assign mac_vld   = s2_vld_q;
  assign mac_a     = s2_vld_q ? a_rdata : '0;
  assign mac_b     = s2_vld_q ? b_rdata : '0;
  assign mac_cnt   = {{(CNT_W-LOG2N){1'b0}}, s2_k_q};
  assign c_we      = cap_vld_q[MAC_LAT-1];
  assign c_addr    = c_we ? cap_addr_q[MAC_LAT-1] : '0;
  assign c_wdata   = !c_we ? '0 :
                     (SAT_EN && (mac_acc > SAT_MAX)) ? SAT_MAX : mac_acc;

endmodule

// File: tb/tb_mat_mul_seq.sv
// Bench for mat_mul_seq: RAM and MAC environment, cycle-level model of the expected outputs.
module tb_mat_mul_seq;
  import mat_mul_pkg::*;

  localparam int LOG2N  = 3;
  localparam int N      = 8;
  localparam int N3     = N * N * N;
  localparam int LAT    = 1;
  localparam int AW     = 2 * LOG2N;
  localparam int QW     = AW + ACC_W;
  localparam int DONE_R = N3 + LAT + 2;
`ifdef MAT_MUL_SAT_EN
  localparam bit               SAT    = 1'b1;
  localparam logic [ACC_W-1:0] LIT_FF = 22'h00FFFF;
`else
  localparam bit               SAT    = 1'b0;
  localparam logic [ACC_W-1:0] LIT_FF = 22'h07F008;
`endif

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic              busy, done, rd_en, mac_vld, c_we;
  logic [AW-1:0]     a_addr, b_addr, c_addr;
  logic [7:0]        a_rdata = '0, b_rdata = '0, mac_a, mac_b;
  logic [CNT_W-1:0]  mac_cnt;
  logic [ACC_W-1:0]  mac_acc, c_wdata;
  state_e            dbg_state;

  mat_mul_seq #(.LOG2N(LOG2N), .MAC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .rd_en(rd_en),
    .a_addr(a_addr), .b_addr(b_addr), .a_rdata(a_rdata), .b_rdata(b_rdata),
    .mac_a(mac_a), .mac_b(mac_b), .mac_cnt(mac_cnt), .mac_vld(mac_vld), .mac_acc(mac_acc),
    .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  initial forever #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // environment: sync-read operand RAMs and a MAC with LAT-cycle result latency
  logic [7:0]       mem_a [N*N];
  logic [7:0]       mem_b [N*N];
  logic [ACC_W-1:0] acc_run = '0;
  logic [ACC_W-1:0] acc_pipe [LAT];
  logic [ACC_W-1:0] acc_nxt;

  always @(posedge clk) if (rd_en) begin
    a_rdata <= mem_a[a_addr];
    b_rdata <= mem_b[b_addr];
  end

  always @(posedge clk) begin
    if (rst) begin
      acc_run <= '0;
      for (int n = 0; n < LAT; n++) acc_pipe[n] <= '0;
    end else begin
      acc_nxt = mac_vld ? (((mac_cnt == 0) ? '0 : acc_run) + ACC_W'(mac_a) * ACC_W'(mac_b)) : acc_run;
      acc_run     <= acc_nxt;
      acc_pipe[0] <= acc_nxt;
      for (int n = 1; n < LAT; n++) acc_pipe[n] <= acc_pipe[n-1];
    end
  end
  assign mac_acc = acc_pipe[LAT-1];

  // scoreboard
  int checks = 0, errors = 0;
  logic [QW-1:0] exp_q[$];
  bit  run_on = 1'b0;
  int  run_s = 0, run_wr = 0, lit_mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] dot(input int i, input int j);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(mem_a[i*N+k]) * int'(mem_b[k*N+j]);
    if (SAT && s > 'h00FFFF) s = 'h00FFFF;
    return ACC_W'(s);
  endfunction

  always @(negedge clk) begin : cmp
    int r, n, wn;
    bit e_busy, e_rd, e_vld, e_done, e_we;
    logic [QW-1:0] e;
    r      = cyc - run_s;
    wn     = r - 1 - LAT;
    e_busy = run_on && r >= 1 && r <= DONE_R;
    e_rd   = run_on && r >= 1 && r <= N3;
    e_vld  = run_on && r >= 2 && r <= N3 + 1;
    e_done = run_on && r == DONE_R;
    e_we   = run_on && wn >= N && (wn % N) == 0 && (wn / N) <= N * N;
    chk("busy", busy, e_busy);
    chk("rd_en", rd_en, e_rd);
    chk("done", done, e_done);
    chk("mac_vld", mac_vld, e_vld);
    chk("c_we", c_we, e_we);
    chk("dbg_idle", dbg_state == ST_IDLE, !e_busy);
    if (e_rd) begin
      n = r - 1;
      chk("a_addr", a_addr, (n / (N*N)) * N + n % N);
      chk("b_addr", b_addr, (n % N) * N + (n / N) % N);
    end
    if (e_vld) begin
      n = r - 2;
      chk("mac_cnt", mac_cnt, n % N);
      chk("mac_a", mac_a, mem_a[(n / (N*N)) * N + n % N]);
      chk("mac_b", mac_b, mem_b[(n % N) * N + (n / N) % N]);
    end else begin
      chk("mac_idle", {mac_a, mac_b, mac_cnt}, 0);
    end
    if (c_we) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        run_wr++;
        chk("c_addr", c_addr, e[QW-1:ACC_W]);
        chk("c_wdata", c_wdata, e[ACC_W-1:0]);
        if (lit_mode == 1) chk("lit_ident", c_wdata, mem_b[e[QW-1:ACC_W]]);
        if (lit_mode == 2) chk("lit_ff", c_wdata, LIT_FF);
      end
    end else begin
      chk("c_idle", {c_addr, c_wdata}, 0);
    end
    if (done) begin
      chk("wr_count", run_wr, 64);
      chk("done_lat", r, 515);
    end
    if (rst) begin
      run_on = 1'b0;
      exp_q.delete();
    end else if (start && (!run_on || r > DONE_R)) begin
      run_on = 1'b1;
      run_s  = cyc;
      run_wr = 0;
      for (int ei = 0; ei < N*N; ei++) exp_q.push_back({AW'(ei), dot(ei / N, ei % N)});
    end
  end

  // driver tasks
  task automatic pulse(input int d);
    repeat (d) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int  n = 0;
    bit  got = 1'b0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout waited=%0d cycles", budget);
    end
  endtask

  task automatic fill_random();
    for (int x = 0; x < N*N; x++) begin
      mem_a[x] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      mem_b[x] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // identity A, ramp B: C must equal B
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mem_a[r*N+c] = (r == c) ? 8'd1 : 8'd0;
        mem_b[r*N+c] = 8'(r * 8 + c);
      end
    lit_mode = 1;
    pulse(1);
    wait_done(600);
    lit_mode = 0;

    // all-ones bytes: worst-case dot product
    for (int x = 0; x < N*N; x++) begin
      mem_a[x] = 8'hFF;
      mem_b[x] = 8'hFF;
    end
    repeat (3) @(posedge clk);
    #1 lit_mode = 2;
    pulse(1);
    wait_done(600);
    lit_mode = 0;

    // start re-pulsed during a run, including in the DONE cycle
    fill_random();
    repeat (2) @(posedge clk);
    #1;
    pulse(1);
    pulse(9);
    pulse(289);
    pulse(214);
    repeat (10) @(posedge clk);
    #1;

    // reset at cycle 100 of a run, then a clean rerun
    fill_random();
    pulse(1);
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    pulse(1);
    wait_done(600);

    // start the cycle after done: identical second run
    pulse(1);
    wait_done(600);

    // randomized runs with a stray start mid-run
    for (int t = 0; t < 3; t++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1;
      fill_random();
      pulse($urandom_range(1, 6));
      pulse($urandom_range(5, 400));
      wait_done(600);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
